mii_phy_tx_if: RTL
==================

MII_PHY_TX_IF -- requirements
Module: mii_phy_tx_if

Interface
REQ-001 SHALL have parameter PIPE_STAGES, default 1, number of output register stages, legal 1..4.
REQ-002 SHALL have parameter MAX_NIBBLES, default 3060, maximum forwarded nibbles per frame before jabber cut-off.
REQ-003 SHALL have parameter IFG_NIBBLES, default 24, minimum idle nibbles between frames.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of each statistics counter.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mac_mii_tx_clk  input  1  clock; all logic in this domain.
REQ-007 SHALL have ports mac_mii_txd  input  4, mac_mii_tx_en  input  1, mac_mii_tx_er  input  1  MAC transmit nibble stream.
REQ-008 SHALL have ports phy_mii_txd  output  4, phy_mii_tx_en  output  1, phy_mii_tx_er  output  1  guarded stream to PHY, driven directly from the last pipeline stage.
REQ-009 SHALL have ports phy_mii_crs  input  1, phy_mii_col  input  1  asynchronous PHY carrier-sense/collision.
REQ-010 SHALL have ports mac_mii_crs  output  1, mac_mii_col  output  1  synchronised CRS/COL.
REQ-011 SHALL have port clr_stats  input  1  synchronous clear of all statistics counters.
REQ-012 SHALL have ports stat_frame_cnt, stat_jabber_cnt, stat_ifg_viol_cnt  output  CNT_WIDTH  frame, jabber and IFG-violation counts.
REQ-013 SHALL have port jabber_active  output  1  high while the guard FSM is in JABBER.

Function
REQ-014 SHALL run a guard FSM with states IDLE, FRAME, JABBER, IFG, evaluated on mac_mii_tx_en each clock.
REQ-015 IDLE: tx_en=1 -> FRAME, nibble count=1, stat_frame_cnt+1; nibble forwarded.
REQ-016 FRAME: tx_en=1 and count<MAX_NIBBLES -> forward nibble, count+1; tx_en=0 -> IFG, idle count=1.
REQ-017 FRAME: tx_en=1 with count==MAX_NIBBLES -> forward that nibble with tx_er forced 1, enter JABBER, stat_jabber_cnt+1.
REQ-018 JABBER: gated tx_en/tx_er/txd all 0; stay until MAC tx_en=0, then IFG with idle count=1.
REQ-019 IFG: tx_en=0 -> idle count+1; IDLE when idle count reaches IFG_NIBBLES.
REQ-020 IFG: tx_en=1 before IFG_NIBBLES -> stat_ifg_viol_cnt+1, stat_frame_cnt+1, FRAME with count=1, nibble forwarded (frame not dropped).
REQ-021 Whenever gated tx_en=0, gated txd and tx_er SHALL be 0 (MAC tx_er with tx_en=0 is discarded).
REQ-022 In FRAME, MAC tx_er SHALL pass through unchanged (except REQ-017 forcing).
REQ-023 Gated signals SHALL traverse exactly PIPE_STAGES registers; MAC-to-PHY latency = PIPE_STAGES clocks; last stage carries IOB attribute.
REQ-024 phy_mii_crs/phy_mii_col SHALL each pass a 2-flop synchroniser; latency 2 clocks.
REQ-025 Statistics counters SHALL saturate at all-ones, never wrap.
REQ-026 clr_stats SHALL zero all counters next clock and take priority over a same-cycle increment (counter reads 0).
REQ-027 jabber_active SHALL equal (state==JABBER), registered, no combinational path from inputs.

Reset
REQ-028 rst_n low SHALL asynchronously force phy_mii_txd=0, phy_mii_tx_en=0, phy_mii_tx_er=0, all pipeline stages 0, mac_mii_crs=0, mac_mii_col=0, all counters 0, jabber_active=0, FSM IDLE, nibble/idle counts 0.
REQ-029 Reset asserted mid-frame SHALL truncate output immediately; after release with MAC tx_en already 1, first cycle SHALL be treated as a frame start from IDLE (REQ-015).
REQ-030 Deassertion SHALL be synchronous to mac_mii_tx_clk (external synchroniser); no internal reset stretching.

Verification
REQ-031 PIPE_STAGES=1, 100-nibble frame, 30 idle, second frame -> PHY stream equals MAC stream delayed 1 clock, stat_frame_cnt=2, other counters 0.
REQ-032 MAX_NIBBLES=64, 80-nibble frame -> nibbles 1..63 forwarded, nibble 64 with tx_er=1, nibbles 65..80 suppressed, jabber_active high until tx_en falls, stat_jabber_cnt=1.
REQ-033 IFG_NIBBLES=24, frame, 10 idle, frame -> second frame forwarded intact, stat_ifg_viol_cnt=1, stat_frame_cnt=2.
REQ-034 PIPE_STAGES=4, MAC tx_er=1 with tx_en=0 -> PHY tx_er stays 0; frame latency measured 4 clocks.
REQ-035 Pulse phy_mii_col for 1 clock -> mac_mii_col high 1 clock, 2 clocks later; rst_n low mid-frame -> all PHY outputs 0 same cycle; clr_stats coincident with frame start -> stat_frame_cnt=0.

Source files
------------

// File: rtl/mii_phy_tx_if.sv
// MII transmit guard between MAC and PHY: jabber cut-off, inter-frame-gap policing,
// output retiming and CRS/COL synchronisation, with saturating statistics.
module mii_phy_tx_if #(
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned MAX_NIBBLES = 3060,
  parameter int unsigned IFG_NIBBLES = 24,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 rst_n,
  input  logic                 mac_mii_tx_clk,
  input  logic [3:0]           mac_mii_txd,
  input  logic                 mac_mii_tx_en,
  input  logic                 mac_mii_tx_er,
  output logic [3:0]           phy_mii_txd,
  output logic                 phy_mii_tx_en,
  output logic                 phy_mii_tx_er,
  input  logic                 phy_mii_crs,
  input  logic                 phy_mii_col,
  output logic                 mac_mii_crs,
  output logic                 mac_mii_col,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] stat_frame_cnt,
  output logic [CNT_WIDTH-1:0] stat_jabber_cnt,
  output logic [CNT_WIDTH-1:0] stat_ifg_viol_cnt,
  output logic                 jabber_active
);

  localparam int unsigned NibW  = (MAX_NIBBLES > 1) ? $clog2(MAX_NIBBLES + 1) : 1;
  localparam int unsigned IdleW = (IFG_NIBBLES > 1) ? $clog2(IFG_NIBBLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StFrame, StJabber, StIfg} state_e;

  state_e           state_q, state_d;
  logic [NibW-1:0]  nib_cnt_q, nib_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [IdleW-1:0] idle_inc;
  logic             at_limit;

  logic             fwd, force_er, frame_start, ifg_viol;
  logic [5:0]       gated;

  assign idle_inc = idle_cnt_q + 1'b1;
  // nib_cnt counts nibbles already forwarded; the incoming one is number nib_cnt+1,
  // so the MAX_NIBBLES-th nibble is the one that gets the forced error.
  assign at_limit = (nib_cnt_q == NibW'(MAX_NIBBLES - 1));

  always_ff @(posedge mac_mii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      nib_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      nib_cnt_q  <= nib_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nib_cnt_d  = nib_cnt_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mac_mii_tx_en) begin
          state_d   = StFrame;
          nib_cnt_d = NibW'(1);
        end
      end
      StFrame: begin
        if (mac_mii_tx_en) begin
          if (at_limit) begin
            state_d = StJabber;
          end else begin
            nib_cnt_d = nib_cnt_q + 1'b1;
          end
        end else if (IFG_NIBBLES <= 1) begin
          state_d    = StIdle;
          idle_cnt_d = '0;
        end else begin
          state_d    = StIfg;
          idle_cnt_d = IdleW'(1);
        end
      end
      StJabber: begin
        if (!mac_mii_tx_en) begin
          if (IFG_NIBBLES <= 1) begin
            state_d    = StIdle;
            idle_cnt_d = '0;
          end else begin
            state_d    = StIfg;
            idle_cnt_d = IdleW'(1);
          end
        end
      end
      StIfg: begin
        if (mac_mii_tx_en) begin
          state_d    = StFrame;
          nib_cnt_d  = NibW'(1);
          idle_cnt_d = '0;
        end else if (idle_inc == IdleW'(IFG_NIBBLES)) begin
          state_d    = StIdle;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fwd         = 1'b0;
    force_er    = 1'b0;
    frame_start = 1'b0;
    ifg_viol    = 1'b0;
    unique case (state_q)
      StIdle: begin
        fwd         = mac_mii_tx_en;
        frame_start = mac_mii_tx_en;
      end
      StFrame: begin
        fwd      = mac_mii_tx_en;
        force_er = mac_mii_tx_en & at_limit;
      end
      StIfg: begin
        fwd         = mac_mii_tx_en;
        frame_start = mac_mii_tx_en;
        ifg_viol    = mac_mii_tx_en;
      end
      default: ;
    endcase
    gated = fwd ? {1'b1, mac_mii_tx_er | force_er, mac_mii_txd} : 6'd0;
  end

  // Retiming pipeline; the final stage is kept separate so it can be packed into the IOB.
  logic [5:0] pre_out;
  (* IOB = "TRUE" *) logic [5:0] out_q;

  if (PIPE_STAGES > 1) begin : g_pre
    logic [5:0] pre_q [PIPE_STAGES-1];
    always_ff @(posedge mac_mii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < PIPE_STAGES - 1; i++) pre_q[i] <= '0;
      end else begin
        pre_q[0] <= gated;
        for (int unsigned i = 1; i < PIPE_STAGES - 1; i++) pre_q[i] <= pre_q[i-1];
      end
    end
    assign pre_out = pre_q[PIPE_STAGES-2];
  end else begin : g_nopre
    assign pre_out = gated;
  end

  always_ff @(posedge mac_mii_tx_clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= pre_out;
  end

  assign phy_mii_tx_en = out_q[5];
  assign phy_mii_tx_er = out_q[4];
  assign phy_mii_txd   = out_q[3:0];

  logic crs_meta_q, crs_q, col_meta_q, col_q, jabber_q;

  always_ff @(posedge mac_mii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      crs_meta_q <= 1'b0;
      crs_q      <= 1'b0;
      col_meta_q <= 1'b0;
      col_q      <= 1'b0;
      jabber_q   <= 1'b0;
    end else begin
      crs_meta_q <= phy_mii_crs;
      crs_q      <= crs_meta_q;
      col_meta_q <= phy_mii_col;
      col_q      <= col_meta_q;
      jabber_q   <= (state_d == StJabber);
    end
  end

  assign mac_mii_crs   = crs_q;
  assign mac_mii_col   = col_q;
  assign jabber_active = jabber_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && !(&v)) ? v + 1'b1 : v;
  endfunction

  logic [CNT_WIDTH-1:0] frame_cnt_q, jabber_cnt_q, ifg_viol_cnt_q;

  always_ff @(posedge mac_mii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q    <= '0;
      jabber_cnt_q   <= '0;
      ifg_viol_cnt_q <= '0;
    end else if (clr_stats) begin
      frame_cnt_q    <= '0;
      jabber_cnt_q   <= '0;
      ifg_viol_cnt_q <= '0;
    end else begin
      frame_cnt_q    <= sat_inc(frame_cnt_q, frame_start);
      jabber_cnt_q   <= sat_inc(jabber_cnt_q, force_er);
      ifg_viol_cnt_q <= sat_inc(ifg_viol_cnt_q, ifg_viol);
    end
  end

  assign stat_frame_cnt    = frame_cnt_q;
  assign stat_jabber_cnt   = jabber_cnt_q;
  assign stat_ifg_viol_cnt = ifg_viol_cnt_q;

endmodule
